// File: rtl/pio_arb_pkg.sv
// Shared types and defaults for the PIO output arbiter.
package pio_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    ACK   = 2'd3
  } arb_state_t;

  localparam int         ARB_DATA_W   = 32;
  localparam logic [1:0] ARB_PIO_ADDR = 2'd0;

endpackage

// File: rtl/pio_out_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after rr_ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic               valid,
  output logic [IDX_W-1:0]   win
);

  // Scan from the farthest candidate down so the nearest one to rr_ptr wins.
  always_comb begin
    int idx;
    idx   = 0;
    valid = 1'b0;
    win   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = (32'(rr_ptr) + k) % NUM_REQ;
      if (req[idx[IDX_W-1:0]]) begin
        valid = 1'b1;
        win   = idx[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/pio_out_arbiter.sv
// Round-robin arbiter sharing the PIO output write port; masked set/clear on a shadow image.
// Optional readback check after each write is enabled by defining PIO_READBACK_EN.
module pio_out_arbiter
  import pio_arb_pkg::*;
#(
  parameter int         NUM_REQ  = 4,
  parameter int         DATA_W   = ARB_DATA_W,
  parameter logic [1:0] PIO_ADDR = ARB_PIO_ADDR
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic [NUM_REQ-1:0]          req,
  input  logic [NUM_REQ*DATA_W-1:0]   req_mask,
  input  logic [NUM_REQ*DATA_W-1:0]   req_value,
  output logic [NUM_REQ-1:0]          ack,
  output logic [1:0]                  avm_address,
  output logic                        avm_chipselect,
  output logic                        avm_write_n,
  output logic [DATA_W-1:0]           avm_writedata,
  input  logic [DATA_W-1:0]           avm_readdata,
  output logic [DATA_W-1:0]           shadow_out,
  output logic                        busy,
  output logic                        err_mismatch
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t         state;
  logic [IDX_W-1:0]   gnt;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   pick;
  logic               pick_vld;
  logic [DATA_W-1:0]  shadow;
  logic [DATA_W-1:0]  next_shadow;
  logic [DATA_W-1:0]  pick_mask;
  logic [DATA_W-1:0]  pick_value;

  function automatic logic [DATA_W-1:0] merge_bits(input logic [DATA_W-1:0] base,
                                                   input logic [DATA_W-1:0] m,
                                                   input logic [DATA_W-1:0] v);
    return (base & ~m) | (v & m);
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] cur);
    return (cur == IDX_W'(NUM_REQ - 1)) ? '0 : cur + 1'b1;
  endfunction

  function automatic logic [NUM_REQ-1:0] one_hot(input logic [IDX_W-1:0] sel);
    return {{(NUM_REQ-1){1'b0}}, 1'b1} << sel;
  endfunction

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_rr_pick (
    .req    (req),
    .rr_ptr (rr_ptr),
    .valid  (pick_vld),
    .win    (pick)
  );

  assign pick_mask     = req_mask[32'(pick) * DATA_W +: DATA_W];
  assign pick_value    = req_value[32'(pick) * DATA_W +: DATA_W];
  assign avm_address   = PIO_ADDR;
  assign avm_writedata = next_shadow;
  assign shadow_out    = shadow;
  assign busy          = (state != IDLE);

`ifdef PIO_READBACK_EN
  logic err_q;
  assign err_mismatch = err_q;
`else
  logic unused_readdata;
  assign unused_readdata = ^avm_readdata;
  assign err_mismatch    = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state          <= IDLE;
      gnt            <= '0;
      rr_ptr         <= '0;
      shadow         <= '0;
      next_shadow    <= '0;
      ack            <= '0;
      avm_chipselect <= 1'b0;
      avm_write_n    <= 1'b1;
`ifdef PIO_READBACK_EN
      err_q          <= 1'b0;
`endif
    end else begin
      ack <= '0;
      case (state)
        // Grant: mask/value are captured here and never looked at again.
        IDLE: begin
          if (pick_vld) begin
            gnt            <= pick;
            next_shadow    <= merge_bits(shadow, pick_mask, pick_value);
            avm_chipselect <= 1'b1;
            avm_write_n    <= 1'b0;
            state          <= WRITE;
          end
        end
        WRITE: begin
          shadow      <= next_shadow;
          avm_write_n <= 1'b1;
`ifdef PIO_READBACK_EN
          state <= READ;
`else
          avm_chipselect <= 1'b0;
          ack            <= one_hot(gnt);
          state          <= ACK;
`endif
        end
`ifdef PIO_READBACK_EN
        READ: begin
          avm_chipselect <= 1'b0;
          if (avm_readdata != shadow) err_q <= 1'b1;
          ack   <= one_hot(gnt);
          state <= ACK;
        end
`endif
        ACK: begin
          rr_ptr <= next_ptr(gnt);
          state  <= IDLE;
        end
        default: begin
          avm_chipselect <= 1'b0;
          avm_write_n    <= 1'b1;
          state          <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/pio_out_arbiter.md
Name: pio_out_arbiter

Overview:
- Shares the single Avalon-MM write port of the 32-bit pin-output PIO between NUM_REQ requesters (ECU tasks, PWM/fault logic).
- Keeps a shadow copy of the PIO output register. Serves one masked set/clear request at a time, in round-robin order. Issues one Avalon write per request, then acknowledges the requester.
- Sits between the requesters and the PIO slave port inside the sys fabric.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 32, PIO data width.
- PIO_ADDR, 2'd0, Avalon word address of the PIO data register.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req  in  NUM_REQ  per-requester request; held high until the matching ack
- req_mask  in  NUM_REQ*DATA_W  per-requester bit mask, slice i = bits [i*DATA_W +: DATA_W]
- req_value  in  NUM_REQ*DATA_W  per-requester new bit values, same slicing
- ack  out  NUM_REQ  one-cycle completion pulse, one-hot
- avm_address  out  2  PIO address
- avm_chipselect  out  1  PIO chip select
- avm_write_n  out  1  PIO active-low write
- avm_writedata  out  DATA_W  PIO write data
- avm_readdata  in  DATA_W  PIO read data (combinational, zero wait states)
- shadow_out  out  DATA_W  current committed pin image
- busy  out  1  high whenever state != IDLE
- err_mismatch  out  1  sticky readback error (see Optional Feature)

Behaviour:
- Reset values:
  - shadow = 0 (matches the PIO reset value); ack = 0.
  - avm_chipselect = 0, avm_write_n = 1, avm_address = PIO_ADDR, avm_writedata = 0.
  - busy = 0, err_mismatch = 0; rr_ptr = 0; state = IDLE.
- State machine: IDLE -> WRITE -> [READ] -> ACK -> IDLE.
- IDLE, when any req bit is set:
  - Round-robin pick starts at index rr_ptr and wraps modulo NUM_REQ; the first set bit wins.
  - Latch the winner index into gnt.
  - Register next_shadow = (shadow & ~mask[gnt]) | (value[gnt] & mask[gnt]).
  - Go to WRITE.
- WRITE (exactly 1 cycle):
  - avm_chipselect = 1, avm_write_n = 0, avm_writedata = next_shadow, avm_address = PIO_ADDR.
  - On exit, shadow <= next_shadow.
  - Go to ACK, or to READ when the feature is enabled.
- ACK (1 cycle):
  - ack[gnt] = 1; rr_ptr <= (gnt + 1) mod NUM_REQ.
  - Go to IDLE.
- Latency: req sampled in IDLE at cycle 0; write strobe in cycle 1; ack in cycle 2. Back-to-back service is possible, so throughput is 1 request per 3 cycles (4 with readback).
- Mask/value are latched at grant. Changes after grant are ignored.
- A requester must drop req in the cycle after ack. A req still high in the cycle ack is high is not re-granted, because ack and IDLE never overlap.
- A req withdrawn before grant is dropped silently, with no ack.
- mask = 0 still performs a write of the unchanged shadow (refresh) and acks.
- Simultaneous requests: only the winner is served. Losers stay pending and are served in later rounds. No starvation: worst-case wait is NUM_REQ-1 services.
- Outside WRITE/READ: avm_chipselect = 0, avm_write_n = 1.
- shadow_out = shadow (registered).
- Reset asserted mid-operation: everything returns to its reset value immediately. No ack is issued. Requesters re-request after reset.

Optional Feature:
- Macro PIO_READBACK_EN.
- Defined:
  - The READ state follows WRITE for 1 cycle: avm_chipselect = 1, avm_write_n = 1, avm_address = PIO_ADDR.
  - avm_readdata is compared with shadow at the cycle end. On mismatch, err_mismatch sets and stays set until reset.
  - Ack is delayed to cycle 3.
- Not defined: no READ state; err_mismatch is tied 0; avm_readdata is unused.

Decomposition:
- Package pio_arb_pkg: state enum (IDLE, WRITE, READ, ACK), DATA_W default, PIO_ADDR constant.
- One sub-module, rr_pick: a combinational round-robin priority picker. Inputs req and rr_ptr; outputs a valid flag and the winner index. Reusable by other shared-resource arbiters.

Test Plan:
- Reset, then req[0] with mask=0x0000_00FF, value=0x0000_00A5 -> write of 0x0000_00A5 in cycle 1, ack[0] in cycle 2, shadow_out=0x0000_00A5.
- Then req[1] with mask=0x0000_000F, value=0 -> writedata=0x0000_00A0; other bits are preserved.
- All four req raised together, each setting one distinct bit -> grants in order 0,1,2,3. Four write strobes spaced 3 cycles apart; final shadow has all four bits set.
- req[3] served, then req[0] and req[3] raised together -> req[0] wins (rr_ptr wrapped to 0).
- reset_n pulsed low during WRITE -> chipselect drops at once, shadow_out=0, no ack. After release, the pending req is re-served normally.
- With PIO_READBACK_EN, readdata forced to 0xDEAD_BEEF during READ -> err_mismatch=1 and held; ack arrives in cycle 3. Without the macro, ack arrives in cycle 2 and err_mismatch stays 0.
